// File: rtl/psum_requant.sv
// Accumulates NUM_GROUPS adder-tree partial sums, adds bias, rounds half-to-even and saturates to Q(FRAC_BITS).
// Latency: 2 cycles from the last group's sum_valid to q_valid. Optional ReLU clamp under PSUM_REQUANT_RELU_EN.
// Backpressure: one-entry q_valid/q_ready register; a result arriving while it is full and not accepted is dropped and sets overrun.
module psum_requant #(
    parameter int BITSIZE    = 14,
    parameter int FRAC_BITS  = 7,
    parameter int NUM_GROUPS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BITSIZE+6:0]   sum_in,
    input  logic                 sum_valid,
    input  logic [BITSIZE-1:0]   bias,
    output logic [BITSIZE-1:0]   q_out,
    output logic                 q_valid,
    input  logic                 q_ready,
    output logic [6:0]           grp_cnt,
    output logic                 overrun
);
    localparam int ACC_W = BITSIZE + 15;
    localparam int IN_W  = BITSIZE + 7;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (BITSIZE - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] r_total;
    logic                    r_vld;

    logic signed [ACC_W-1:0] sum_ext;
    logic signed [ACC_W-1:0] bias_sh;
    logic signed [ACC_W-1:0] acc_base;
    logic                    last_grp;

    assign sum_ext  = {{(ACC_W - IN_W){sum_in[IN_W-1]}}, sum_in};
    assign bias_sh  = {{(ACC_W - BITSIZE - FRAC_BITS){bias[BITSIZE-1]}}, bias, {FRAC_BITS{1'b0}}};
    assign acc_base = (grp_cnt == 7'd0) ? '0 : acc;
    assign last_grp = (grp_cnt == 7'(NUM_GROUPS - 1));

    // Accumulate; the closing group hands the biased total to stage R and clears
    // the accumulator in the same cycle so the next pixel can start immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            grp_cnt <= '0;
            r_total <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (sum_valid) begin
                if (last_grp) begin
                    r_total <= acc_base + sum_ext + bias_sh;
                    r_vld   <= 1'b1;
                    acc     <= '0;
                    grp_cnt <= '0;
                end else begin
                    acc     <= acc_base + sum_ext;
                    grp_cnt <= grp_cnt + 7'd1;
                end
            end
        end
    end

    logic signed [ACC_W-1:0] trunc;
    logic signed [ACC_W-1:0] rounded;
    logic                    round_bit;
    logic                    sticky;
    logic                    round_up;
    logic [BITSIZE-1:0]      sat_val;
    logic [BITSIZE-1:0]      res_val;

    assign trunc     = r_total >>> FRAC_BITS;
    assign round_bit = r_total[FRAC_BITS-1];
    assign sticky    = |r_total[FRAC_BITS-2:0];
    assign round_up  = round_bit && (sticky || trunc[0]);
    assign rounded   = trunc + $signed({{(ACC_W - 1){1'b0}}, round_up});

    always_comb begin
        sat_val = rounded[BITSIZE-1:0];
        if (rounded > SAT_MAX) begin
            sat_val = SAT_MAX[BITSIZE-1:0];
        end else if (rounded < SAT_MIN) begin
            sat_val = SAT_MIN[BITSIZE-1:0];
        end
    end

`ifdef PSUM_REQUANT_RELU_EN
    assign res_val = sat_val[BITSIZE-1] ? '0 : sat_val;
`else
    assign res_val = sat_val;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            q_out   <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (r_vld) begin
                if (!q_valid || q_ready) begin
                    q_out   <= res_val;
                    q_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (q_valid && q_ready) begin
                q_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/psum_requant.md
# psum_requant

Back end of the convolution datapath: consumes the wide signed partial sums emitted by the 27-input pipelined adder tree (`sum_output`/`data_valid`), accumulates `NUM_GROUPS` of them per output pixel, adds a per-channel bias, rounds to nearest even, and saturates back to the `BITSIZE`-bit Q(`FRAC_BITS`) activation format. The result is presented through a one-entry valid/ready output register to the activation/writeback stage.

## Interface
- `BITSIZE`, 14, activation width; output format Q(`FRAC_BITS`).
- `FRAC_BITS`, 7, fractional bits of activations/weights; `sum_in` carries 2·`FRAC_BITS`.
- `NUM_GROUPS`, 4, adder-tree results accumulated per output (1..128).
- Localparam `ACC_W` = `BITSIZE`+15, accumulator width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `sum_in` in `BITSIZE`+7: signed partial sum from the adder tree.
- `sum_valid` in 1: `sum_in` valid this cycle (adder tree `data_valid`).
- `bias` in `BITSIZE`: signed Q(`FRAC_BITS`) bias; sampled with the last group.
- `q_out` out `BITSIZE`: signed requantized result.
- `q_valid` out 1: `q_out` holds an unconsumed result.
- `q_ready` in 1: downstream accepts `q_out` when `q_valid`.
- `grp_cnt` out 7: groups accumulated so far for the current output.
- `overrun` out 1: sticky, a result was dropped.

## Operation
- ACC state: each `sum_valid` cycle adds sign-extended `sum_in` to `acc` (first group loads instead of adds); `grp_cnt` increments.
- On the `NUM_GROUPS`-th valid: `total = acc + sum_in + (sign-extended bias <<< FRAC_BITS)` is registered into stage R; `acc` and `grp_cnt` clear in the same cycle, so the next group's `sum_valid` may arrive immediately.
- Stage R (1 cycle): `trunc = total >>> FRAC_BITS` (arithmetic); `round_bit = total[FRAC_BITS-1]`; `sticky = |total[FRAC_BITS-2:0]`; `trunc += 1` if `round_bit && (sticky || trunc[0])`.
- Saturation: clamp to [−2^(BITSIZE−1), 2^(BITSIZE−1)−1]; the rounded value is kept at `ACC_W` bits, so no intermediate wrap.
- Output register loads when `!q_valid || q_ready`; otherwise the new result is dropped, `q_out` is unchanged, and `overrun` is set.
- `q_valid` clears on `q_valid && q_ready` with no simultaneous load; simultaneous accept and load keeps `q_valid`=1 with the new data.
- No arithmetic wrap is possible for `NUM_GROUPS` ≤ 128.

## Timing
- Reset: `acc`=0, `grp_cnt`=0, stage R empty, `q_out`=0, `q_valid`=0, `overrun`=0. Reset during accumulation discards partial data, and the next `sum_valid` is group 0.
- Latency: last-group `sum_valid` at cycle N produces `q_valid`=1 at N+2, with `q_ready` high or the register empty.
- Sustained throughput: one result per `NUM_GROUPS` valid cycles. With `NUM_GROUPS`=1, one result per cycle.
- `sum_valid` low cycles are holes; accumulation state is held.

## Configuration
- `PSUM_REQUANT_RELU_EN` defined: after saturation, negative results are replaced by 0, giving range [0, 2^(BITSIZE−1)−1].
- Undefined: signed saturated result is passed unchanged.

## Test plan
- 4×`sum_in`=4096, `bias`=0 → `q_out`=128 (1.0) two cycles after the 4th valid, `q_valid`=1.
- Rounding, one group each via `NUM_GROUPS`=1: totals 64 → 0, 192 → 2, −64 → 0, 65 → 1, −192 → −2 (ties to even).
- 4×`sum_in`=1000000 → 8191; 4×−1000000 → −8192. With `PSUM_REQUANT_RELU_EN`, the negative case gives 0.
- Sums 0, `bias`=5 → 5; `bias`=−3 with sums 0 → −3.
- `q_ready` held low across two results → first result retained, `overrun`=1. Raising `q_ready` with a same-cycle load → new data presented, `q_valid` stays 1.
- `rst` after 2 of 4 groups, then 4 groups of 4096 → `q_out`=128, with no contribution from the pre-reset sums.
